// File: rtl/cavlc_runbefore_enc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cavlc_pkg : shared types and constants for the run_before encoder    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cavlc_pkg;

  typedef logic [3:0] run_t;
  typedef logic [4:0] zl_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    OUT  = 2'd2
  } rb_state_e;

  localparam int RB_MAX_LEN = 11;

endpackage
`default_nettype wire

// File: rtl/cavlc_rb_vlc_lut.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cavlc_rb_vlc_lut : run_before codeword lookup (zerosLeft, run)       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cavlc_rb_vlc_lut
  import cavlc_pkg::*;
(
  input  run_t                  rb,
  input  zl_t                   zl,
  output logic [RB_MAX_LEN-1:0] bits,
  output logic [3:0]            len,
  output logic                  illegal
);

  // Every codeword value fits in 3 bits; long codes are zeros then a single 1.
  logic [3:0] w_val;

  always_comb begin
    w_val   = 4'd0;
    len     = 4'd0;
    illegal = (zl == 5'd0) || ({1'b0, rb} > zl);
    case (zl)
      5'd0: ;
      5'd1: begin
        w_val = (rb == 4'd0) ? 4'd1 : 4'd0;
        len   = 4'd1;
      end
      5'd2: begin
        if (rb == 4'd0) begin
          w_val = 4'd1;
          len   = 4'd1;
        end else begin
          w_val = 4'd2 - rb;
          len   = 4'd2;
        end
      end
      5'd3: begin
        w_val = 4'd3 - rb;
        len   = 4'd2;
      end
      5'd4: begin
        if (rb < 4'd3) begin
          w_val = 4'd3 - rb;
          len   = 4'd2;
        end else begin
          w_val = 4'd4 - rb;
          len   = 4'd3;
        end
      end
      5'd5: begin
        if (rb < 4'd2) begin
          w_val = 4'd3 - rb;
          len   = 4'd2;
        end else begin
          w_val = 4'd5 - rb;
          len   = 4'd3;
        end
      end
      5'd6: begin
        len = 4'd3;
        case (rb)
          4'd0: begin w_val = 4'd3; len = 4'd2; end
          4'd1: w_val = 4'd0;
          4'd2: w_val = 4'd1;
          4'd3: w_val = 4'd3;
          4'd4: w_val = 4'd2;
          4'd5: w_val = 4'd5;
          default: w_val = 4'd4;
        endcase
      end
      default: begin
        if (rb <= 4'd6) begin
          w_val = 4'd7 - rb;
          len   = 4'd3;
        end else begin
          w_val = 4'd1;
          len   = rb - 4'd3;
        end
      end
    endcase
  end

  assign bits = RB_MAX_LEN'(w_val);

endmodule
`default_nettype wire

// File: rtl/cavlc_runbefore_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cavlc_runbefore_enc : CAVLC run_before field encoder, valid/ready    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cavlc_runbefore_enc
  import cavlc_pkg::*;
#(
  parameter int MAX_COEFF   = 16,
  parameter int CODE_W      = 32,
  parameter int SYM_PER_CYC = 1,
  parameter int LEN_W       = $clog2(CODE_W + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             total_zeros,
  input  logic [4:0]             total_coeff,
  input  logic [4*MAX_COEFF-1:0] run_list,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CODE_W-1:0]      out_code,
  output logic [LEN_W-1:0]       out_len,
  output logic                   out_err
);

  localparam int SEL_W = (MAX_COEFF > 1) ? $clog2(MAX_COEFF) : 1;
  localparam int SUM_W = LEN_W + 1;

  rb_state_e          r_state;
  rb_state_e          w_state_nxt;
  run_t               r_run [MAX_COEFF];
  zl_t                r_zl;
  logic [4:0]         r_idx;
  logic [4:0]         r_nsym;
  logic [LEN_W-1:0]   r_len;
  logic [CODE_W-1:0]  r_code;

  logic [4:0] w_nsym_in;
  logic       w_bad_in;
  logic       w_skip_in;

  assign w_nsym_in = (total_coeff == 5'd0) ? 5'd0 : total_coeff - 5'd1;
  assign w_bad_in  = ({1'b0, total_coeff} > 6'(MAX_COEFF)) ||
                     (({1'b0, total_coeff} + {1'b0, total_zeros}) > 6'(MAX_COEFF));
  assign w_skip_in = w_bad_in || (w_nsym_in == 5'd0) || (total_zeros == 5'd0);

  // Symbol slots chained combinationally; a slot only codes if its predecessor did.
  for (genvar s = 0; s < SYM_PER_CYC; s++) begin : g_slot
    zl_t                   w_zl_i,   w_zl_o;
    logic [4:0]            w_idx_i,  w_idx_o;
    logic [LEN_W-1:0]      w_len_i,  w_len_o;
    logic [CODE_W-1:0]     w_code_i, w_code_o;
    logic                  w_go_i,   w_ok;
    logic                  w_err_i,  w_err_o;
    run_t                  w_rb;
    logic [RB_MAX_LEN-1:0] w_bits;
    logic [3:0]            w_l;
    logic                  w_ill, w_act, w_ovf;
    logic [SUM_W-1:0]      w_sum;

    if (s == 0) begin : g_first
      assign w_zl_i   = r_zl;
      assign w_idx_i  = r_idx;
      assign w_len_i  = r_len;
      assign w_code_i = r_code;
      assign w_go_i   = 1'b1;
      assign w_err_i  = 1'b0;
    end else begin : g_chain
      assign w_zl_i   = g_slot[s-1].w_zl_o;
      assign w_idx_i  = g_slot[s-1].w_idx_o;
      assign w_len_i  = g_slot[s-1].w_len_o;
      assign w_code_i = g_slot[s-1].w_code_o;
      assign w_go_i   = g_slot[s-1].w_ok;
      assign w_err_i  = g_slot[s-1].w_err_o;
    end

    assign w_act = w_go_i && (w_idx_i < r_nsym) && (w_zl_i != 5'd0);
    assign w_rb  = r_run[w_idx_i[SEL_W-1:0]];

    cavlc_rb_vlc_lut u_lut (
      .rb      (w_rb),
      .zl      (w_zl_i),
      .bits    (w_bits),
      .len     (w_l),
      .illegal (w_ill)
    );

    assign w_sum    = SUM_W'(w_len_i) + SUM_W'(w_l);
    assign w_ovf    = w_sum > SUM_W'(CODE_W);
    assign w_ok     = w_act && !w_ill && !w_ovf;
    assign w_err_o  = w_err_i || (w_act && (w_ill || w_ovf));
    assign w_code_o = w_ok ? ((w_code_i << w_l) | CODE_W'(w_bits)) : w_code_i;
    assign w_len_o  = w_ok ? w_sum[LEN_W-1:0] : w_len_i;
    assign w_zl_o   = w_ok ? (w_zl_i - zl_t'(w_rb)) : w_zl_i;
    assign w_idx_o  = w_ok ? (w_idx_i + 5'd1) : w_idx_i;
  end

  zl_t               w_zl_f;
  logic [4:0]        w_idx_f;
  logic [LEN_W-1:0]  w_len_f;
  logic [CODE_W-1:0] w_code_f;
  logic              w_err_f;
  logic              w_done;

  assign w_zl_f   = g_slot[SYM_PER_CYC-1].w_zl_o;
  assign w_idx_f  = g_slot[SYM_PER_CYC-1].w_idx_o;
  assign w_len_f  = g_slot[SYM_PER_CYC-1].w_len_o;
  assign w_code_f = g_slot[SYM_PER_CYC-1].w_code_o;
  assign w_err_f  = g_slot[SYM_PER_CYC-1].w_err_o;
  assign w_done   = w_err_f || (w_idx_f == r_nsym) || (w_zl_f == 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_skip_in ? OUT : ENC;
      ENC:     if (w_done) w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_COEFF; i++) r_run[i] <= '0;
      r_zl     <= '0;
      r_idx    <= '0;
      r_nsym   <= '0;
      r_len    <= '0;
      r_code   <= '0;
      out_code <= '0;
      out_len  <= '0;
      out_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          for (int i = 0; i < MAX_COEFF; i++) r_run[i] <= run_list[4*i +: 4];
          r_zl   <= total_zeros;
          r_idx  <= '0;
          r_nsym <= w_nsym_in;
          r_len  <= '0;
          r_code <= '0;
          if (w_skip_in) begin
            out_code <= '0;
            out_len  <= '0;
            out_err  <= w_bad_in;
          end
        end
        ENC: begin
          r_zl   <= w_zl_f;
          r_idx  <= w_idx_f;
          r_len  <= w_len_f;
          r_code <= w_code_f;
          if (w_done) begin
            out_code <= w_code_f;
            out_len  <= w_len_f;
            out_err  <= w_err_f;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cavlc_runbefore_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cavlc_runbefore_enc : bench for 1- and 2-symbol encoder variants  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cavlc_runbefore_enc;

  localparam int MAXC = 16;
  localparam int CW   = 32;
  localparam int LW   = $clog2(CW + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [4:0]      total_zeros = '0;
  logic [4:0]      total_coeff = '0;
  logic [4*MAXC-1:0] run_list = '0;

  logic in_ready1, out_valid1, out_err1, in_ready2, out_valid2, out_err2;
  logic [CW-1:0] out_code1, out_code2;
  logic [LW-1:0] out_len1, out_len2;

  always #5 clk = ~clk;

  cavlc_runbefore_enc #(.MAX_COEFF(MAXC), .CODE_W(CW), .SYM_PER_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .total_zeros(total_zeros), .total_coeff(total_coeff), .run_list(run_list),
    .out_valid(out_valid1), .out_ready(out_ready), .out_code(out_code1),
    .out_len(out_len1), .out_err(out_err1));

  cavlc_runbefore_enc #(.MAX_COEFF(MAXC), .CODE_W(CW), .SYM_PER_CYC(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .total_zeros(total_zeros), .total_coeff(total_coeff), .run_list(run_list),
    .out_valid(out_valid2), .out_ready(out_ready), .out_code(out_code2),
    .out_len(out_len2), .out_err(out_err2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Codeword of run rb with zl zeros left, as a '0'/'1' string.
  function automatic string cw_str(int zl, int rb);
    string row, cur;
    int t;
    cur = "";
    if (zl > 6) begin
      if (rb <= 6) begin
        for (int b = 2; b >= 0; b--)
          if ((((7 - rb) >> b) & 1) == 1) cur = {cur, "1"}; else cur = {cur, "0"};
      end else begin
        for (int k = 0; k < rb - 4; k++) cur = {cur, "0"};
        cur = {cur, "1"};
      end
      return cur;
    end
    case (zl)
      1: row = "1 0";
      2: row = "1 01 00";
      3: row = "11 10 01 00";
      4: row = "11 10 01 001 000";
      5: row = "11 10 011 010 001 000";
      6: row = "11 000 001 011 010 101 100";
      default: row = "";
    endcase
    t = 0;
    for (int k = 0; k < row.len(); k++) begin
      if (row.substr(k, k) == " ") begin
        if (t == rb) return cur;
        t++;
        cur = "";
      end else begin
        cur = {cur, row.substr(k, k)};
      end
    end
    return cur;
  endfunction

  function automatic void model(input int tc, input int tz, input logic [63:0] runs,
                                input int spc, output logic [63:0] code, output int len,
                                output bit err, output int lat);
    int nsym, zl, rb, attempts;
    string s;
    err = (tc > MAXC) || (tc + tz > MAXC);
    code = '0; len = 0; attempts = 0;
    nsym = (tc == 0) ? 0 : tc - 1;
    zl = tz;
    if (!err) begin
      for (int i = 0; i < nsym && zl > 0; i++) begin
        attempts++;
        rb = int'(runs[4*i +: 4]);
        if (rb > zl) begin err = 1; break; end
        s = cw_str(zl, rb);
        if (len + s.len() > CW) begin err = 1; break; end
        for (int k = 0; k < s.len(); k++) code = {code[62:0], (s.substr(k, k) == "1")};
        len += s.len();
        zl -= rb;
      end
    end
    lat = (attempts + spc - 1) / spc + 1;
  endfunction

  logic [63:0] g_code [2];
  int          g_len  [2];
  bit          g_err  [2];
  int          g_lat  [2];

  // Send one descriptor to both DUTs, record results and latency, then release.
  task automatic run_block(input int tc, input int tz, input logic [63:0] runs, input int stall);
    chk("in_ready1 before send", in_ready1, 1);
    chk("in_ready2 before send", in_ready2, 1);
    total_coeff = 5'(tc);
    total_zeros = 5'(tz);
    run_list = runs;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    g_lat[0] = 0; g_lat[1] = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (out_valid1 && g_lat[0] == 0) begin
        g_lat[0] = cyc; g_code[0] = 64'(out_code1); g_len[0] = int'(out_len1); g_err[0] = out_err1;
      end
      if (out_valid2 && g_lat[1] == 0) begin
        g_lat[1] = cyc; g_code[1] = 64'(out_code2); g_len[1] = int'(out_len2); g_err[1] = out_err2;
      end
      if (g_lat[0] != 0 && g_lat[1] != 0) break;
      @(posedge clk); #1;
    end
    if (g_lat[0] == 0) chk("timeout dut1", 0, 1);
    if (g_lat[1] == 0) chk("timeout dut2", 0, 1);
    for (int k = 0; k < stall; k++) begin
      total_coeff = 5'd2; total_zeros = 5'd1; run_list = '0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("stall code1", 64'(out_code1), g_code[0]);
      chk("stall len1", 64'(out_len1), 64'(g_len[0]));
      chk("stall valid1", out_valid1, 1);
      chk("stall in_ready1", in_ready1, 0);
      chk("stall code2", 64'(out_code2), g_code[1]);
      chk("stall in_ready2", in_ready2, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("released valid1", out_valid1, 0);
    chk("released valid2", out_valid2, 0);
  endtask

  task automatic check_results(input string tag, input logic [63:0] code, input int len,
                               input bit err, input int lat1, input int lat2);
    chk({tag, " code1"}, g_code[0], code);
    chk({tag, " len1"}, 64'(g_len[0]), 64'(len));
    chk({tag, " err1"}, 64'(g_err[0]), 64'(err));
    chk({tag, " lat1"}, 64'(g_lat[0]), 64'(lat1));
    chk({tag, " code2"}, g_code[1], code);
    chk({tag, " len2"}, 64'(g_len[1]), 64'(len));
    chk({tag, " err2"}, 64'(g_err[1]), 64'(err));
    chk({tag, " lat2"}, 64'(g_lat[1]), 64'(lat2));
  endtask

  typedef struct {
    int          tc;
    int          tz;
    logic [63:0] runs;
    logic [63:0] code;
    int          len;
    bit          err;
    int          lat1;
    int          lat2;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [63:0] e_code;
    int e_len, e_lat1, e_lat2, tc, tz, rem, rb;
    bit e_err;
    logic [63:0] runs;

    vecs.push_back('{5, 3, 64'h11001, 64'h2D, 6, 1'b0, 5, 3});
    vecs.push_back('{4, 2, 64'h002, 64'h0, 2, 1'b0, 2, 2});
    vecs.push_back('{2, 14, 64'hE, 64'h1, 11, 1'b0, 2, 2});
    vecs.push_back('{0, 0, 64'h0, 64'h0, 0, 1'b0, 1, 1});
    vecs.push_back('{1, 7, 64'h5, 64'h0, 0, 1'b0, 1, 1});
    vecs.push_back('{6, 0, 64'h11111, 64'h0, 0, 1'b0, 1, 1});
    vecs.push_back('{3, 1, 64'h2, 64'h0, 0, 1'b1, 2, 2});
    vecs.push_back('{12, 8, 64'h0, 64'h0, 0, 1'b1, 1, 1});
    vecs.push_back('{17, 0, 64'h0, 64'h0, 0, 1'b1, 1, 1});
    vecs.push_back('{3, 9, 64'h32, 64'h2C, 6, 1'b0, 3, 2});
    vecs.push_back('{4, 6, 64'h021, 64'h0F, 8, 1'b0, 4, 3});
    vecs.push_back('{4, 3, 64'h31, 64'h2, 2, 1'b1, 3, 2});
    vecs.push_back('{3, 4, 64'h03, 64'h3, 4, 1'b0, 3, 2});
    vecs.push_back('{4, 5, 64'h140, 64'h32, 6, 1'b0, 4, 3});

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready1", in_ready1, 1);
    chk("reset out_valid1", out_valid1, 0);
    chk("reset out_code1", 64'(out_code1), 0);
    chk("reset out_len1", 64'(out_len1), 0);
    chk("reset out_err1", out_err1, 0);
    chk("reset in_ready2", in_ready2, 1);
    chk("reset out_valid2", out_valid2, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_block(vecs[i].tc, vecs[i].tz, vecs[i].runs, 0);
      check_results($sformatf("vec%0d", i), vecs[i].code, vecs[i].len, vecs[i].err,
                    vecs[i].lat1, vecs[i].lat2);
    end

    // Backpressure: result held for 10 cycles while a second descriptor is offered.
    run_block(5, 3, 64'h11001, 10);
    check_results("stall", 64'h2D, 6, 1'b0, 5, 3);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("no phantom block1", out_valid1, 0);
      chk("no phantom block2", out_valid2, 0);
    end

    // Asynchronous reset in the middle of encoding.
    total_coeff = 5'd9; total_zeros = 5'd7; run_list = '0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid-enc in_ready1", in_ready1, 0);
    rst = 1'b0;
    #1;
    chk("async rst out_valid1", out_valid1, 0);
    chk("async rst in_ready1", in_ready1, 1);
    chk("async rst in_ready2", in_ready2, 1);
    chk("async rst out_len1", 64'(out_len1), 0);
    @(negedge clk);
    rst = 1'b1;
    run_block(vecs[0].tc, vecs[0].tz, vecs[0].runs, 0);
    check_results("after rst", vecs[0].code, vecs[0].len, vecs[0].err, vecs[0].lat1, vecs[0].lat2);

    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        tc = int'($urandom_range(0, 17));
        tz = int'($urandom_range(0, 20));
      end else begin
        tc = int'($urandom_range(0, MAXC));
        tz = int'($urandom_range(0, MAXC - tc));
      end
      runs = '0;
      rem = tz;
      for (int i = 0; i < MAXC - 1; i++) begin
        if ($urandom_range(0, 11) == 0) rb = int'($urandom_range(0, 15));
        else rb = int'($urandom_range(0, (rem > 15) ? 15 : rem));
        runs[4*i +: 4] = 4'(rb);
        if (rb <= rem) rem -= rb;
      end
      model(tc, tz, runs, 1, e_code, e_len, e_err, e_lat1);
      model(tc, tz, runs, 2, e_code, e_len, e_err, e_lat2);
      run_block(tc, tz, runs, 0);
      check_results($sformatf("rand%0d tc=%0d tz=%0d", it, tc, tz), e_code, e_len, e_err,
                    e_lat1, e_lat2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
